// File: rtl/axi_sts_arb_pkg.sv
// axi_sts_arb_pkg: shared FSM state encoding and AXI response codes for the status-read arbiter
package axi_sts_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_sts_rr_grant.sv
// axi_sts_rr_grant: two-way round-robin pick; on a tie the port not served last wins
module axi_sts_rr_grant (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);
  assign any   = |req;
  assign grant = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/axi_sts_read_arbiter.sv
// axi_sts_read_arbiter: shares one AXI4-Lite status read channel between two slave ports, one read in flight
module axi_sts_read_arbiter
  import axi_sts_arb_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic                      s0_axi_arvalid,
  output logic                      s0_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]                s0_axi_rresp,
  output logic                      s0_axi_rvalid,
  input  logic                      s0_axi_rready,
  input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic                      s1_axi_arvalid,
  output logic                      s1_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]                s1_axi_rresp,
  output logic                      s1_axi_rvalid,
  input  logic                      s1_axi_rready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);
  state_t                    state_q, state_d;
  logic                      last_q, gnt_q, gnt, any;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic [1:0]                resp_q;
  logic [15:0]               cnt_q;
  logic                      timeout, accept;

  axi_sts_rr_grant u_grant (
    .req   ({s1_axi_arvalid, s0_axi_arvalid}),
    .last  (last_q),
    .grant (gnt),
    .any   (any)
  );

  assign timeout = cnt_q == 16'(TIMEOUT_CYCLES - 1);
  assign accept  = gnt_q ? s1_axi_rready : s0_axi_rready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any ? ADDR : IDLE;
      ADDR:    state_d = m_axi_arready ? DATA : ADDR;
      DATA:    state_d = (m_axi_rvalid || timeout) ? RESP : DATA;
      RESP:    state_d = accept ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state_q <= IDLE;
    else state_q <= state_d;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      last_q <= 1'b1;
      gnt_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      resp_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == IDLE && any) begin
        gnt_q  <= gnt;
        addr_q <= gnt ? s1_axi_araddr : s0_axi_araddr;
      end
      // counter is held at zero through ADDR so DATA always starts from a cleared count
      if (state_q == ADDR) cnt_q <= '0;
      else if (state_q == DATA && !m_axi_rvalid) cnt_q <= cnt_q + 16'd1;
      if (state_q == DATA && (m_axi_rvalid || timeout)) begin
        data_q <= m_axi_rvalid ? m_axi_rdata : '0;
        resp_q <= m_axi_rvalid ? m_axi_rresp : RESP_SLVERR;
      end
      if (state_q == RESP && accept) last_q <= gnt_q;
    end

  assign s0_axi_arready = state_q == IDLE && s0_axi_arvalid && !gnt;
  assign s1_axi_arready = state_q == IDLE && s1_axi_arvalid && gnt;
  assign m_axi_arvalid  = state_q == ADDR;
  assign m_axi_araddr   = addr_q;
  assign m_axi_rready   = state_q != ADDR;
  assign s0_axi_rvalid  = state_q == RESP && !gnt_q;
  assign s1_axi_rvalid  = state_q == RESP && gnt_q;
  assign s0_axi_rdata   = data_q;
  assign s1_axi_rdata   = data_q;
  assign s0_axi_rresp   = resp_q;
  assign s1_axi_rresp   = resp_q;
endmodule

// File: tb/tb_axi_sts_read_arbiter.sv
// tb_axi_sts_read_arbiter: directed vector table plus randomized traffic against a transaction-level model
module tb_axi_sts_read_arbiter;
  import axi_sts_arb_pkg::*;
  localparam int TO = 8;

  logic        aclk = 1'b0, aresetn = 1'b0;
  logic [31:0] s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
  logic [31:0] s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
  logic [1:0]  s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
  logic        s0_axi_arvalid, s0_axi_arready, s0_axi_rvalid, s0_axi_rready;
  logic        s1_axi_arvalid, s1_axi_arready, s1_axi_rvalid, s1_axi_rready;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  int          n_tests = 0, n_fail = 0;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0, a1, d;
    logic [1:0]  r;
    int          dly;
    int          hold;
    bit          drop;
    int          ep;
    logic [31:0] ea, ed;
    logic [1:0]  er;
  } vec_t;

  vec_t        tbl[9];
  vec_t        mr_vec;
  bit          pend[2], busy[2];
  logic [31:0] paddr[2];
  int          gap[2];
  int          ph, ar_dly, r_cnt, lat, done;
  bit          last_m, cur_port, gp;
  logic [31:0] cur_addr;

  axi_sts_read_arbiter #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axi_araddr(s0_axi_araddr), .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp), .s0_axi_rvalid(s0_axi_rvalid),
    .s0_axi_rready(s0_axi_rready),
    .s1_axi_araddr(s1_axi_araddr), .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
    .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp), .s1_axi_rvalid(s1_axi_rvalid),
    .s1_axi_rready(s1_axi_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return a[3:2];
  endfunction

  task automatic tick;
    @(posedge aclk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v);
    int  t, n;
    bit  ok;
    logic p;
    s0_axi_rready  = 1'b0;
    s1_axi_rready  = 1'b0;
    s0_axi_arvalid = v.req[0];
    s0_axi_araddr  = v.a0;
    s1_axi_arvalid = v.req[1];
    s1_axi_araddr  = v.a1;
    t = 0;
    #1;
    while (!(s0_axi_arready || s1_axi_arready) && t < 10) begin
      tick;
      #1;
      t++;
    end
    chk("arb_wait", t < 10, 1);
    p = s1_axi_arready;
    chk("grant", p, v.ep);
    chk("arready_onehot", s0_axi_arready && s1_axi_arready, 0);
    tick;
    if (p) s1_axi_arvalid = 1'b0;
    else s0_axi_arvalid = 1'b0;
    if (v.drop) begin
      s0_axi_arvalid = 1'b0;
      s1_axi_arvalid = 1'b0;
    end
    #1;
    chk("addr_arvalid", m_axi_arvalid, 1);
    chk("addr_araddr", m_axi_araddr, v.ea);
    chk("addr_rready", m_axi_rready, 0);
    chk("addr_arready_busy", s0_axi_arready || s1_axi_arready, 0);
    m_axi_arready = 1'b1;
    tick;
    m_axi_arready = 1'b0;
    n = (v.dly < 0) ? TO : v.dly;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      ok &= !(s0_axi_rvalid || s1_axi_rvalid) && !s0_axi_arready && !s1_axi_arready;
      tick;
    end
    if (n > 0) chk("no_early_rvalid", ok, 1);
    if (v.dly >= 0) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = v.d;
      m_axi_rresp  = v.r;
      tick;
      m_axi_rvalid = 1'b0;
      m_axi_rdata  = $urandom;
    end
    #1;
    chk("rvalid", p ? s1_axi_rvalid : s0_axi_rvalid, 1);
    chk("rvalid_other", p ? s0_axi_rvalid : s1_axi_rvalid, 0);
    chk("rdata", p ? s1_axi_rdata : s0_axi_rdata, v.ed);
    chk("rresp", p ? s1_axi_rresp : s0_axi_rresp, v.er);
    ok = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = $urandom;
      m_axi_rresp  = 2'($urandom);
      tick;
      #1;
      ok &= (p ? s1_axi_rvalid : s0_axi_rvalid) && (p ? s1_axi_rdata : s0_axi_rdata) == v.ed &&
            (p ? s1_axi_rresp : s0_axi_rresp) == v.er && !m_axi_arvalid;
    end
    if (v.hold > 0) chk("hold_stable", ok, 1);
    m_axi_rvalid = 1'b0;
    if (p) s1_axi_rready = 1'b1;
    else s0_axi_rready = 1'b1;
    tick;
    s0_axi_rready = 1'b0;
    s1_axi_rready = 1'b0;
    #1;
    chk("idle_rvalid", s0_axi_rvalid || s1_axi_rvalid, 0);
    chk("idle_rready", m_axi_rready, 1);
    chk("idle_arvalid", m_axi_arvalid, 0);
    if (v.drop) begin
      ok = 1'b1;
      repeat (3) begin
        tick;
        #1;
        ok &= !m_axi_arvalid;
      end
      chk("dropped_not_served", ok, 1);
    end
  endtask

  initial begin
    tbl[0] = '{2'b11, 32'h00, 32'h08, 32'h1111_1111, 2'b00, 0, 0, 1'b0, 0, 32'h00, 32'h1111_1111, 2'b00};
    tbl[1] = '{2'b10, 32'h00, 32'h08, 32'h2222_2222, 2'b00, 2, 5, 1'b0, 1, 32'h08, 32'h2222_2222, 2'b00};
    tbl[2] = '{2'b01, 32'h04, 32'h00, 32'hDEAD_BEEF, 2'b00, 0, 0, 1'b0, 0, 32'h04, 32'hDEAD_BEEF, 2'b00};
    tbl[3] = '{2'b11, 32'h14, 32'h10, 32'h3333_3333, 2'b01, 3, 0, 1'b0, 1, 32'h10, 32'h3333_3333, 2'b01};
    tbl[4] = '{2'b11, 32'h14, 32'h1C, 32'h4444_4444, 2'b11, 1, 0, 1'b0, 0, 32'h14, 32'h4444_4444, 2'b11};
    tbl[5] = '{2'b11, 32'h20, 32'h1C, 32'h0, 2'b00, -1, 0, 1'b0, 1, 32'h1C, 32'h0, 2'b10};
    tbl[6] = '{2'b11, 32'h20, 32'h24, 32'h0, 2'b00, -1, 0, 1'b0, 0, 32'h20, 32'h0, 2'b10};
    tbl[7] = '{2'b11, 32'h28, 32'h24, 32'h5555_5555, 2'b00, 7, 0, 1'b0, 1, 32'h24, 32'h5555_5555, 2'b00};
    tbl[8] = '{2'b11, 32'h28, 32'h2C, 32'h6666_6666, 2'b00, 6, 0, 1'b1, 0, 32'h28, 32'h6666_6666, 2'b00};
    mr_vec = '{2'b10, 32'h0, 32'h30, 32'h7777_7777, 2'b00, 1, 0, 1'b0, 1, 32'h30, 32'h7777_7777, 2'b00};
    s0_axi_araddr = '0; s0_axi_arvalid = 1'b0; s0_axi_rready = 1'b0;
    s1_axi_araddr = '0; s1_axi_arvalid = 1'b0; s1_axi_rready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rvalid = 1'b0;
    repeat (2) tick;
    chk("rst_m_arvalid", m_axi_arvalid, 0);
    chk("rst_m_araddr", m_axi_araddr, 0);
    chk("rst_m_rready", m_axi_rready, 1);
    chk("rst_rvalid", {s1_axi_rvalid, s0_axi_rvalid}, 0);
    chk("rst_rdata", {s1_axi_rdata, s0_axi_rdata}, 0);
    chk("rst_rresp", {s1_axi_rresp, s0_axi_rresp}, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick;
    foreach (tbl[i]) do_txn(tbl[i]);

    s0_axi_arvalid = 1'b1;
    s0_axi_araddr  = 32'h40;
    #1;
    chk("mr_arready", s0_axi_arready, 1);
    tick;
    s0_axi_arvalid = 1'b0;
    m_axi_arready  = 1'b1;
    tick;
    m_axi_arready = 1'b0;
    #1;
    aresetn = 1'b0;
    #1;
    chk("mr_m_arvalid", m_axi_arvalid, 0);
    chk("mr_rvalid", {s1_axi_rvalid, s0_axi_rvalid}, 0);
    chk("mr_m_araddr", m_axi_araddr, 0);
    chk("mr_rdata", s0_axi_rdata, 0);
    chk("mr_idle_rready", m_axi_rready, 1);
    @(negedge aclk);
    aresetn = 1'b1;
    tick;
    do_txn(mr_vec);

    aresetn = 1'b0;
    tick;
    @(negedge aclk);
    aresetn = 1'b1;
    tick;
    last_m = 1'b1;
    ph = 0; ar_dly = 0; r_cnt = 0; lat = 0; done = 0; cur_port = 1'b0; cur_addr = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; busy[p] = 1'b0; paddr[p] = '0; gap[p] = $urandom_range(0, 3);
    end
    for (int cyc = 0; cyc < 4000 && done < 40; cyc++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && !busy[p]) begin
          if (gap[p] == 0) begin
            pend[p]  = 1'b1;
            paddr[p] = $urandom_range(0, 1023) << 2;
          end else gap[p]--;
        end
      s0_axi_arvalid = pend[0];
      s0_axi_araddr  = paddr[0];
      s1_axi_arvalid = pend[1];
      s1_axi_araddr  = paddr[1];
      s0_axi_rready  = 1'($urandom_range(0, 1));
      s1_axi_rready  = 1'($urandom_range(0, 1));
      #1;
      if (ph == 0 && m_axi_arvalid) begin
        ph = 1;
        ar_dly = $urandom_range(0, 2);
        chk("rnd_araddr", m_axi_araddr, cur_addr);
      end
      if (ph == 1) chk("rnd_arvalid_held", m_axi_arvalid, 1);
      m_axi_arready = ph == 1 && ar_dly == 0;
      m_axi_rvalid  = (ph == 2 && r_cnt == lat) || (ph == 0 && $urandom_range(0, 5) == 0);
      m_axi_rdata   = (ph == 2) ? mem_data(cur_addr) : $urandom;
      m_axi_rresp   = (ph == 2) ? mem_resp(cur_addr) : 2'($urandom);
      #1;
      if (s0_axi_arready || s1_axi_arready) begin
        gp = s1_axi_arready;
        chk("rnd_grant", gp, (pend[0] && pend[1]) ? !last_m : pend[1]);
        chk("rnd_arready_onehot", s0_axi_arready && s1_axi_arready, 0);
        cur_port = gp;
        cur_addr = paddr[gp];
        pend[gp] = 1'b0;
        busy[gp] = 1'b1;
        lat = $urandom_range(0, 9);
      end
      if (s0_axi_rvalid || s1_axi_rvalid) begin
        chk("rnd_rvalid_port", {s1_axi_rvalid, s0_axi_rvalid}, cur_port ? 2'b10 : 2'b01);
        chk("rnd_rdata", cur_port ? s1_axi_rdata : s0_axi_rdata, lat < TO ? mem_data(cur_addr) : 32'h0);
        chk("rnd_rresp", cur_port ? s1_axi_rresp : s0_axi_rresp, lat < TO ? mem_resp(cur_addr) : RESP_SLVERR);
        if (cur_port ? s1_axi_rready : s0_axi_rready) begin
          busy[cur_port] = 1'b0;
          last_m = cur_port;
          gap[cur_port] = $urandom_range(0, 3);
          done++;
        end
      end
      if (ph == 1) begin
        if (ar_dly == 0) begin
          ph = 2;
          r_cnt = 0;
        end else ar_dly--;
      end else if (ph == 2) begin
        if (r_cnt == lat || r_cnt == TO - 1) ph = 0;
        else r_cnt++;
      end
      tick;
    end
    chk("rnd_completed", done >= 40, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_sts_read_arbiter.md
AXI_STS_READ_ARBITER -- requirements
Module: axi_sts_read_arbiter

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, meaning the read data width in bits.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning the read address width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the number of DATA-state cycles after which the block gives up waiting for downstream data; legal range is 2..65535.
REQ-004 SHALL have port aclk, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port aresetn, input, width 1: asynchronous, active-low reset.
REQ-006 SHALL have, for each slave port sN (N = 0, 1), the following ports:
- sN_axi_araddr, input, AXI_ADDR_WIDTH.
- sN_axi_arvalid, input, 1.
- sN_axi_arready, output, 1.
- sN_axi_rdata, output, AXI_DATA_WIDTH.
- sN_axi_rresp, output, 2.
- sN_axi_rvalid, output, 1.
- sN_axi_rready, input, 1.
REQ-007 SHALL have the following master ports, which connect to one shared AXI4-Lite status-register read channel:
- m_axi_araddr, output, AXI_ADDR_WIDTH.
- m_axi_arvalid, output, 1.
- m_axi_arready, input, 1.
- m_axi_rdata, input, AXI_DATA_WIDTH.
- m_axi_rresp, input, 2.
- m_axi_rvalid, input, 1.
- m_axi_rready, output, 1.

Function
REQ-008 SHALL implement a four-state FSM with states IDLE, ADDR, DATA and RESP, and SHALL allow at most one transaction in flight.
REQ-009 In IDLE, the block SHALL choose a port from the asserted sN_axi_arvalid by round-robin arbitration.
- If only one port requests, that port is granted.
- If both request, the port not served last is granted.
- After reset, the "last served" pointer SHALL equal 1, so s0 wins the first tie.
REQ-010 In IDLE, sN_axi_arready SHALL equal (sN_axi_arvalid AND grant==N), combinationally. The handshake cycle latches sN_axi_araddr and the grant, and the FSM SHALL move to ADDR.
REQ-011 In ADDR, m_axi_arvalid SHALL be 1 and m_axi_araddr SHALL be the latched address. m_axi_arvalid SHALL never deassert before m_axi_arready. On m_axi_arready the FSM SHALL move to DATA.
REQ-012 m_axi_rready SHALL be 0 in ADDR and 1 in IDLE, DATA and RESP. A beat with m_axi_rvalid in IDLE or RESP SHALL be discarded.
REQ-013 In DATA, on m_axi_rvalid the block SHALL register m_axi_rdata and m_axi_rresp into the response holding register and move to RESP.
REQ-014 A 16-bit counter SHALL clear on entry to DATA and increment each DATA cycle without m_axi_rvalid.
- When the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL move to RESP with rdata set to 0 and rresp set to 2'b10 (SLVERR).
- If m_axi_rvalid arrives in that same cycle, it SHALL take priority and be returned as a normal response.
REQ-015 In RESP, the granted port's sN_axi_rvalid SHALL be 1, and its rdata/rresp SHALL come from the holding register, stable until accepted.
- The other port's rvalid SHALL be 0.
- On sN_axi_rready the FSM SHALL move to IDLE and update the last-served pointer to N.
REQ-016 The handshake latency SHALL be as follows:
- a slave address handshake in cycle T gives m_axi_arvalid=1 in cycle T+1;
- a downstream rvalid in cycle D gives sN_axi_rvalid=1 in cycle D+1.
REQ-017 A new arbitration SHALL NOT occur in the cycle RESP completes; IDLE is always occupied for at least one cycle.
REQ-018 A requester whose arvalid drops while it is not granted SHALL NOT be served.
REQ-019 sN_axi_arready SHALL be 0 in every state except IDLE.

Reset
REQ-020 While aresetn=0, and asynchronously on its assertion, the block SHALL force:
- FSM to IDLE;
- last-served pointer to 1;
- timeout counter to 0;
- holding registers to 0;
- m_axi_arvalid=0 and m_axi_araddr=0;
- all sN_axi_rvalid=0, all sN_axi_rdata=0, all sN_axi_rresp=0.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction with no response issued. The block SHALL accept a new request no earlier than the first rising edge after aresetn deasserts.

Structure
REQ-022 A shared package axi_sts_arb_pkg SHALL hold:
- the FSM state encoding (2-bit, IDLE=0, ADDR=1, DATA=2, RESP=3);
- RESP_OKAY=2'b00;
- RESP_SLVERR=2'b10.
REQ-023 Round-robin grant selection SHALL be a separate sub-module, axi_sts_rr_grant. It is purely combinational: inputs req[1:0] and last; output grant index and any-request.

Verification
REQ-024 Single read: s0 reads address 0x4 while downstream returns 0xDEADBEEF with OKAY. Required: m_axi_araddr=0x4, and s0 receives rdata 0xDEADBEEF with rresp 0 one cycle after the downstream rvalid.
REQ-025 Contention: s0 and s1 assert arvalid in the same cycle after reset, reading addresses 0x0 and 0x8. Required: s0 is served first, then s1; m_axi_araddr sequence is 0x0, 0x8.
REQ-026 Fairness: both ports request continuously for 6 transactions. Required: grants alternate 0,1,0,1,0,1 and neither port waits more than one transaction.
REQ-027 Timeout: TIMEOUT_CYCLES=8 and downstream never asserts rvalid after arready. Required: the granted port gets rresp 2'b10 with rdata 0 exactly 8 cycles after entering DATA, and the FSM then returns to IDLE.
REQ-028 Backpressure: s1 holds rready=0 for 5 cycles in RESP. Required: s1_axi_rvalid, rdata and rresp stay stable, and no m_axi_arvalid is issued until s1 accepts.
REQ-029 Reset mid-transaction: drop aresetn while in DATA. Required: immediately all valids are 0 and the FSM is in IDLE, and the next s1 request after release is served normally.
